// File: rtl/bus_pkg.sv
// Shared definitions for the bus DMA master: widths, FSM encoding, memory map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  // Bus memory map
  localparam logic [ADDR_W-1:0] MEM_BASE      = 8'h00;
  localparam logic [ADDR_W-1:0] CORE_REG_BASE = 8'h30;

  // DMA master FSM encoding
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_RDW  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/dma_addr_ctr.sv
// Source/destination address and remaining-word counters for the DMA master.
// Latency: load and increment take effect on the next rising clk.
// Backpressure: none; the FSM only pulses inc on a granted write.
module dma_addr_ctr #(
  parameter int ADDR_W = bus_pkg::ADDR_W,
  parameter int LEN_W  = bus_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] src_init,
  input  logic [ADDR_W-1:0] dst_init,
  input  logic [LEN_W-1:0]  len_init,
  output logic [ADDR_W-1:0] cur_src,
  output logic [ADDR_W-1:0] cur_dst,
  output logic [ADDR_W-1:0] src_nxt,
  output logic              last
);

  logic [LEN_W-1:0] remaining;

  // Addresses wrap naturally at 2^ADDR_W.
  assign src_nxt = cur_src + ADDR_W'(1);
  // The word currently in flight is the final one.
  assign last    = (remaining == LEN_W'(1));

  // Capture the transfer on load, step all three counters per committed word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_src   <= src_init;
      cur_dst   <= dst_init;
      remaining <= len_init;
    end else if (inc) begin
      cur_src   <= src_nxt;
      cur_dst   <= cur_dst + ADDR_W'(1);
      remaining <= remaining - LEN_W'(1);
    end
  end

endmodule

// File: rtl/bus_dma_master.sv
// Bus initiator copying LEN words from src to dst over the shared M_* bus.
// Latency: N words with grant held high -> done at T+2+3N after the start edge.
// Backpressure: grant loss before a write retries the current word from REQ.
module bus_dma_master #(
  parameter int ADDR_W = bus_pkg::ADDR_W,
  parameter int DATA_W = bus_pkg::DATA_W,
  parameter int LEN_W  = bus_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              M_req,
  output logic              M_wr,
  output logic [ADDR_W-1:0] M_addr,
  output logic [DATA_W-1:0] M_dout,
  input  logic              M_grant,
  input  logic [DATA_W-1:0] M_din
);
  import bus_pkg::*;

  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] cur_src;
  logic [ADDR_W-1:0] cur_dst;
  logic [ADDR_W-1:0] src_nxt;
  logic              last;
  logic              ctr_load;
  logic              ctr_inc;

  assign ctr_load = (state == S_IDLE) && start;
  assign ctr_inc  = (state == S_WR) && M_grant;
  // Write data comes straight from the latch, which only changes on entry to WR.
  assign M_dout   = data_q;

  dma_addr_ctr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_ctr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ctr_load),
    .inc      (ctr_inc),
    .src_init (src_addr),
    .dst_init (dst_addr),
    .len_init (len),
    .cur_src  (cur_src),
    .cur_dst  (cur_dst),
    .src_nxt  (src_nxt),
    .last     (last)
  );

  // Transfer FSM; all bus outputs are registered alongside the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      M_req  <= 1'b0;
      M_wr   <= 1'b0;
      M_addr <= '0;
      data_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_REQ;
              M_req <= 1'b1;
              M_wr  <= 1'b0;
            end
          end
        end
        S_REQ: begin
          if (M_grant) begin
            state  <= S_RD;
            M_addr <= cur_src;
          end
        end
        S_RD: begin
          // A grant lost here is caught by the check in RDW.
          state <= S_RDW;
        end
        S_RDW: begin
          if (M_grant) begin
            state  <= S_WR;
            M_wr   <= 1'b1;
            M_addr <= cur_dst;
            data_q <= M_din;
          end else begin
            state <= S_REQ;
          end
        end
        S_WR: begin
          M_wr <= 1'b0;
          if (M_grant) begin
            if (last) begin
              state <= S_DONE;
              done  <= 1'b1;
              M_req <= 1'b0;
            end else begin
              state  <= S_RD;
              M_addr <= src_nxt;
            end
          end else begin
            // Write not taken: re-read and re-write the same word.
            state <= S_REQ;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          M_req <= 1'b0;
          M_wr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma_master.sv
// Self-checking bench for bus_dma_master: bus memory model plus write scoreboard.
// Latency: checks done timing against T+2+3N (plus stall cycles).
// Backpressure: exercises withheld and dropped grants.
module tb_bus_dma_master;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;
  logic [7:0]  len;
  logic        busy;
  logic        done;
  logic        M_req;
  logic        M_wr;
  logic [7:0]  M_addr;
  logic [31:0] M_dout;
  logic        M_grant;
  logic [31:0] M_din;

  int n_checks = 0;
  int n_fail   = 0;
  int n_commits = 0;

  always #5 clk = ~clk;

  bus_dma_master dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .M_req    (M_req),
    .M_wr     (M_wr),
    .M_addr   (M_addr),
    .M_dout   (M_dout),
    .M_grant  (M_grant),
    .M_din    (M_din)
  );

  function automatic logic [31:0] init_val(input logic [7:0] a);
    case (a)
      8'h00:   return 32'd2;
      8'h01:   return 32'd3;
      8'h02:   return 32'hD;
      8'h03:   return 32'd1;
      default: return {24'hC0FFEE, a};
    endcase
  endfunction

  // Bus memory: read data valid one cycle after the address, writes commit on grant.
  logic [31:0] mem [256];
  logic        written [256];
  always @(posedge clk) begin
    M_din <= written[M_addr] ? mem[M_addr] : init_val(M_addr);
    if (M_req && M_wr && M_grant) begin
      mem[M_addr]     <= M_dout;
      written[M_addr] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  // Scoreboard: every granted write must match the next expected write.
  always @(negedge clk) begin
    if (reset_n && M_req && M_wr && M_grant) begin
      n_commits++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(M_addr), 64'hFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(M_addr), 64'(e.a));
        check("wr_data", 64'(M_dout), 64'(e.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    int         drop_cyc;
    int         drop_wr;
    bit         mid_start;
    int         exp_done;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int done_k = -1;
    int wr_seen = 0;
    int bad_wait = 0;
    int bad_busy = 0;
    int req_seen = 0;
    int base = n_commits;
    logic [7:0] a;
    src_addr = v.src;
    dst_addr = v.dst;
    len      = v.len;
    start    = 1'b1;
    M_grant  = (v.drop_cyc == 0);
    for (int i = 0; i < int'(v.len); i++) begin
      wr_t e;
      a = v.src + 8'(i);
      e.a = v.dst + 8'(i);
      e.d = init_val(a);
      exp_q.push_back(e);
    end
    for (int k = 1; k <= 300; k++) begin
      tick();
      start = 1'b0;
      if (v.mid_start && k == 4) begin
        start = 1'b1; src_addr = 8'h80; dst_addr = 8'h90; len = 8'd9;
      end
      if (k <= v.drop_cyc && (M_req !== 1'b1 || M_wr !== 1'b0)) bad_wait++;
      if (M_req) req_seen++;
      if (busy !== 1'b1) bad_busy++;
      if (M_wr) wr_seen++;
      M_grant = (k > v.drop_cyc) && !(M_wr && wr_seen == v.drop_wr);
      if (done) begin
        done_k = k;
        break;
      end
    end
    M_grant = 1'b1;
    check("done_latency", 64'(done_k), 64'(v.exp_done));
    check("busy_during", 64'(bad_busy), 64'd0);
    if (v.drop_cyc > 0) check("wait_req_no_wr", 64'(bad_wait), 64'd0);
    if (v.len == 8'd0) check("len0_no_req", 64'(req_seen), 64'd0);
    tick();
    check("busy_done_after", 64'({busy, done}), 64'd0);
    check("write_count", 64'(n_commits - base), 64'(v.len));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.dst + 8'(i);
      check("dst_mem", 64'(mem[a]), 64'(init_val(v.src + 8'(i))));
    end
    exp_q.delete();
  endtask

  vec_t vecs[6];

  initial begin
    int bad;
    int base;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0;
      written[i] = 1'b0;
    end
    vecs[0] = '{MEM_BASE,      CORE_REG_BASE, 8'd4, 0, 0, 1'b0, 14};
    vecs[1] = '{MEM_BASE,      8'h40,         8'd0, 0, 0, 1'b0, 1};
    vecs[2] = '{MEM_BASE,      CORE_REG_BASE, 8'd4, 5, 0, 1'b0, 19};
    vecs[3] = '{8'h08,         8'h38,         8'd4, 0, 2, 1'b0, 18};
    vecs[4] = '{8'hFE,         8'h10,         8'd3, 0, 0, 1'b0, 11};
    vecs[5] = '{MEM_BASE,      8'h50,         8'd3, 0, 0, 1'b1, 11};

    reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0; M_grant = 1'b1;
    tick();
    tick();
    check("reset_ctrl", 64'({busy, done, M_req, M_wr}), 64'd0);
    check("reset_addr", 64'(M_addr), 64'd0);
    check("reset_dout", 64'(M_dout), 64'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      tick();
    end

    // Reset during RDW of word 1 aborts with no done and no further bus cycles.
    base = n_commits;
    src_addr = MEM_BASE; dst_addr = 8'h60; len = 8'd2; start = 1'b1; M_grant = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_reset_rdw", 64'({M_req, M_wr}), 64'b10);
    reset_n = 1'b0;
    tick();
    check("abort_ctrl", 64'({busy, done, M_req, M_wr}), 64'd0);
    check("abort_addr", 64'(M_addr), 64'd0);
    check("abort_dout", 64'(M_dout), 64'd0);
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done || M_req || busy) bad++;
    end
    check("abort_quiet", 64'(bad), 64'd0);
    check("abort_no_write", 64'(n_commits - base), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
